// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Central stall/flush controller for the 5-stage MIPS pipeline.
//               Optional macro HAZ_PERF_EN adds stall/flush performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter int MD_CYCLES = 4,
    parameter int CNT_W     = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_load_use,
    input  logic        ex_branch_taken,
    input  logic        ex_md_start,
    input  logic        mem_wait,
    input  logic        exc_req,
    output logic [4:0]  stall,
    output logic [4:0]  flush,
    output logic        md_busy,
    output logic        md_done
`ifdef HAZ_PERF_EN
    ,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flush_events
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MD_BUSY = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    localparam logic [4:0] c_STALL_NONE = 5'b00000;
    localparam logic [4:0] c_STALL_LU   = 5'b00011;
    localparam logic [4:0] c_STALL_EX   = 5'b00111;
    localparam logic [4:0] c_STALL_MEM  = 5'b01111;
    localparam logic [4:0] c_FLUSH_NONE = 5'b00000;
    localparam logic [4:0] c_FLUSH_BR   = 5'b00011;
    localparam logic [4:0] c_FLUSH_EXC  = 5'b11111;

    localparam logic [CNT_W-1:0] c_CNT_LOAD = CNT_W'(MD_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        stall       = c_STALL_NONE;
        flush       = c_FLUSH_NONE;
        md_busy     = (r_state == ST_MD_BUSY);
        md_done     = (r_state == ST_DONE);
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;

        if (reset) begin
            md_busy = 1'b0;
            md_done = 1'b0;
        end else if (exc_req) begin
            // Exception aborts any mult/div in flight
            flush       = c_FLUSH_EXC;
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
        end else if (mem_wait) begin
            stall = c_STALL_MEM;
        end else if (r_state == ST_MD_BUSY) begin
            stall     = c_STALL_EX;
            w_cnt_nxt = r_cnt - c_CNT_ONE;
            if (r_cnt <= c_CNT_ONE) begin
                w_state_nxt = ST_DONE;
                w_cnt_nxt   = '0;
            end
        end else if ((r_state == ST_IDLE) && ex_md_start) begin
            // Start cycle counts as the first of MD_CYCLES stall cycles
            stall = c_STALL_EX;
            if (MD_CYCLES <= 1) begin
                w_state_nxt = ST_DONE;
                w_cnt_nxt   = '0;
            end else begin
                w_state_nxt = ST_MD_BUSY;
                w_cnt_nxt   = c_CNT_LOAD;
            end
        end else begin
            if (ex_branch_taken) begin
                flush = c_FLUSH_BR;
            end else if (id_load_use) begin
                stall = c_STALL_LU;
            end
            if (r_state == ST_DONE) begin
                w_state_nxt = ST_IDLE;
            end
        end
    end

`ifdef HAZ_PERF_EN
    logic r_unused_perf;
    assign r_unused_perf = 1'b0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_stall_cycles <= '0;
            perf_flush_events <= '0;
        end else begin
            if ((|stall) && (perf_stall_cycles != 32'hFFFF_FFFF)) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
            if ((|flush) && (perf_flush_events != 32'hFFFF_FFFF)) begin
                perf_flush_events <= perf_flush_events + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_ctrl
// Description : Directed plus randomized bench with a cycle-level behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

    localparam int MD_CYCLES = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       id_load_use = 1'b0;
    logic       ex_branch_taken = 1'b0;
    logic       ex_md_start = 1'b0;
    logic       mem_wait = 1'b0;
    logic       exc_req = 1'b0;
    logic [4:0] stall;
    logic [4:0] flush;
    logic       md_busy;
    logic       md_done;
`ifdef HAZ_PERF_EN
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_flush_events;
`endif

    int checks = 0;
    int errors = 0;

    pipeline_hazard_ctrl #(.MD_CYCLES(MD_CYCLES), .CNT_W(8)) dut (
        .clk             (clk),
        .reset           (reset),
        .id_load_use     (id_load_use),
        .ex_branch_taken (ex_branch_taken),
        .ex_md_start     (ex_md_start),
        .mem_wait        (mem_wait),
        .exc_req         (exc_req),
        .stall           (stall),
        .flush           (flush),
        .md_busy         (md_busy),
        .md_done         (md_done)
`ifdef HAZ_PERF_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flush_events (perf_flush_events)
`endif
    );

    always #5 clk = ~clk;

    // Model: m_left = mult/div stall cycles still owed after the start cycle,
    // m_done = result-drain cycle pending.
    int          m_left = 0;
    bit          m_done = 1'b0;
    longint      m_perf_stall = 0;
    longint      m_perf_flush = 0;

    function automatic logic [4:0] hold_upto(input int n);
        return 5'((1 << n) - 1);
    endfunction

    function automatic void model_out(output logic [4:0] s, output logic [4:0] f,
                                      output logic b, output logic d);
        s = '0; f = '0; b = 1'b0; d = 1'b0;
        if (!reset) begin
            b = (m_left > 0);
            d = m_done;
            if (exc_req)                          f = 5'b11111;
            else if (mem_wait)                    s = hold_upto(4);
            else if (m_left > 0)                  s = hold_upto(3);
            else if (!m_done && ex_md_start)      s = hold_upto(3);
            else if (ex_branch_taken)             f = hold_upto(2);
            else if (id_load_use)                 s = hold_upto(2);
        end
    endfunction

    always @(posedge clk or posedge reset) begin
        logic [4:0] s, f;
        logic b, d;
        if (reset) begin
            m_left = 0; m_done = 1'b0; m_perf_stall = 0; m_perf_flush = 0;
        end else begin
            model_out(s, f, b, d);
            if (s != 0 && m_perf_stall < 64'hFFFF_FFFF) m_perf_stall++;
            if (f != 0 && m_perf_flush < 64'hFFFF_FFFF) m_perf_flush++;
            if (exc_req) begin
                m_left = 0; m_done = 1'b0;
            end else if (!mem_wait) begin
                if (m_left > 0) begin
                    m_left--;
                    if (m_left == 0) m_done = 1'b1;
                end else if (m_done) begin
                    m_done = 1'b0;
                end else if (ex_md_start) begin
                    m_left = MD_CYCLES - 1;
                    if (m_left == 0) m_done = 1'b1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model
    always @(negedge clk) begin
        logic [4:0] s, f;
        logic b, d;
        model_out(s, f, b, d);
        chk("model.stall", 32'(stall), 32'(s));
        chk("model.flush", 32'(flush), 32'(f));
        chk("model.md_busy", 32'(md_busy), 32'(b));
        chk("model.md_done", 32'(md_done), 32'(d));
`ifdef HAZ_PERF_EN
        chk("model.perf_stall", perf_stall_cycles, 32'(m_perf_stall));
        chk("model.perf_flush", perf_flush_events, 32'(m_perf_flush));
`endif
    end

    task automatic drive(input bit lu, input bit br, input bit st, input bit mw, input bit ex);
        id_load_use = lu; ex_branch_taken = br; ex_md_start = st; mem_wait = mw; exc_req = ex;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_now(input string name, input logic [4:0] s, input logic [4:0] f,
                              input bit b, input bit d);
        #2;
        chk({name, ".stall"}, 32'(stall), 32'(s));
        chk({name, ".flush"}, 32'(flush), 32'(f));
        chk({name, ".busy"}, 32'(md_busy), 32'(b));
        chk({name, ".done"}, 32'(md_done), 32'(d));
        tick();
    endtask

    initial begin
        // Reset holds all outputs low even with active inputs
        tick();
        drive(1, 0, 1, 1, 0);
        expect_now("in_reset", 5'b00000, 5'b00000, 0, 0);
        drive(0, 0, 0, 0, 0);
        reset = 1'b0;
        expect_now("idle", 5'b00000, 5'b00000, 0, 0);

        drive(1, 0, 0, 0, 0); expect_now("load_use", 5'b00011, 5'b00000, 0, 0);
        drive(0, 0, 0, 0, 0); expect_now("lu_release", 5'b00000, 5'b00000, 0, 0);
        drive(1, 1, 0, 0, 0); expect_now("branch_over_lu", 5'b00000, 5'b00011, 0, 0);

        // Mult/div held high: 4 stall cycles, one DONE, then idle
        drive(0, 0, 1, 0, 0); expect_now("md_c1", 5'b00111, 5'b00000, 0, 0);
        expect_now("md_c2", 5'b00111, 5'b00000, 1, 0);
        expect_now("md_c3", 5'b00111, 5'b00000, 1, 0);
        expect_now("md_c4", 5'b00111, 5'b00000, 1, 0);
        expect_now("md_done", 5'b00000, 5'b00000, 0, 1);
        drive(0, 0, 0, 0, 0); expect_now("md_after", 5'b00000, 5'b00000, 0, 0);

        // mem_wait freezes the busy window for 2 cycles
        drive(0, 0, 1, 0, 0); expect_now("mw_c1", 5'b00111, 5'b00000, 0, 0);
        drive(0, 0, 0, 1, 0); expect_now("mw_c2", 5'b01111, 5'b00000, 1, 0);
        expect_now("mw_c3", 5'b01111, 5'b00000, 1, 0);
        drive(0, 1, 0, 0, 0); expect_now("mw_c4", 5'b00111, 5'b00000, 1, 0);
        drive(0, 0, 0, 0, 0); expect_now("mw_c5", 5'b00111, 5'b00000, 1, 0);
        expect_now("mw_c6", 5'b00111, 5'b00000, 1, 0);
        drive(0, 1, 0, 0, 0); expect_now("mw_done_br", 5'b00000, 5'b00011, 0, 1);
        drive(0, 0, 0, 0, 0); expect_now("mw_after", 5'b00000, 5'b00000, 0, 0);

        // Exception with mem_wait in the 2nd busy cycle aborts the op
        drive(0, 0, 1, 0, 0); expect_now("exc_c1", 5'b00111, 5'b00000, 0, 0);
        drive(0, 0, 0, 1, 1); expect_now("exc_c2", 5'b00000, 5'b11111, 1, 0);
        drive(0, 0, 0, 0, 0); expect_now("exc_after", 5'b00000, 5'b00000, 0, 0);
        expect_now("exc_after2", 5'b00000, 5'b00000, 0, 0);

`ifdef HAZ_PERF_EN
        reset = 1'b1;
        #2;
        chk("perf_rst_stall", perf_stall_cycles, 32'd0);
        chk("perf_rst_flush", perf_flush_events, 32'd0);
        tick();
        reset = 1'b0;
        drive(1, 0, 0, 0, 0); tick(); tick(); tick();
        drive(0, 1, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0);
        #2;
        chk("perf_stall_3", perf_stall_cycles, 32'd3);
        chk("perf_flush_1", perf_flush_events, 32'd1);
        tick();
`endif

        // Randomized traffic, including occasional mid-operation resets
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            drive($urandom_range(0, 99) < 25, $urandom_range(0, 99) < 15,
                  $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 15,
                  $urandom_range(0, 99) < 4);
            tick();
        end
        reset = 1'b0;
        drive(0, 0, 0, 0, 0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central hazard controller for the 5-stage MIPS pipeline.
- Drives the stall[4:0] and flush[4:0] vectors consumed by the PC and by the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Arbitrates load-use hazards, taken branches/jumps, multi-cycle mult/div, data-memory wait states and exceptions.
- Tracks the mult/div busy window with an internal state machine and cycle counter.

Parameters:
MD_CYCLES, 4, number of EX stall cycles for a mult/div op; legal range 1..255
CNT_W, 8, width of the mult/div down-counter

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
id_load_use  input  1  ID detected a load-use dependency on the instruction in EX
ex_branch_taken  input  1  EX resolved a taken branch or jump
ex_md_start  input  1  EX holds a mult/div instruction
mem_wait  input  1  data memory not ready this cycle
exc_req  input  1  MEM stage raised an exception
stall  output  5  [0]=PC hold, [1]=IF/ID hold, [2]=ID/EX hold, [3]=EX/MEM hold, [4]=MEM/WB hold
flush  output  5  [0]=clear IF/ID, [1]=clear ID/EX, [2]=clear EX/MEM, [3]=clear MEM/WB, [4]=PC redirect to exception vector
md_busy  output  1  state is MD_BUSY
md_done  output  1  mult/div result valid; high for exactly the DONE cycle(s)

Behaviour:
- Stall encoding: stall is always a thermometer from bit 0, one of 00000, 00011, 00111 or 01111.
  - Register k holds when stall[k]=1.
  - Register k loads a bubble when stall[k-1]=1 and stall[k]=0.
- Outputs are combinational from state, counter and inputs.
- While reset is high: stall=0, flush=0, md_busy=0, md_done=0, state=IDLE, counter=0.
- States:
  - IDLE: no mult/div in progress.
  - MD_BUSY: counter counts the remaining stall cycles.
  - DONE: one drain cycle in which the finished mult/div leaves EX; ex_md_start is ignored.
- Priority, highest first:
  1. exc_req: flush=11111, stall=00000. State returns to IDLE next edge and the counter clears, aborting any mult/div.
  2. mem_wait: stall=01111, flush=00000. State and counter are frozen. Branch and load-use are suppressed.
  3. MD_BUSY: stall=00111, flush=00000 (bubble into EX/MEM). Load-use and branch inputs are ignored.
  4. IDLE with ex_md_start=1 (the start cycle): stall=00111. Next edge goes to MD_BUSY with counter=MD_CYCLES-1; if MD_CYCLES=1, next edge goes to DONE.
  5. ex_branch_taken: flush=00011, stall=00000. This also applies in DONE, and it overrides a same-cycle id_load_use, which is wrong-path.
  6. id_load_use: stall=00011, flush=00000.
  7. Otherwise both vectors are 0.
- MD_BUSY counter behaviour:
  - Decrements on every edge not frozen by mem_wait.
  - When counter=1 at an edge, next state is DONE.
- Total stall cycles per mult/div = MD_CYCLES, starting in the cycle ex_md_start is first seen.
- DONE:
  - md_done=1, no mult/div stall.
  - Rules 5 and 6 are evaluated normally.
  - Leaves to IDLE on the first edge with mem_wait=0.
- ex_md_start while in MD_BUSY or DONE is ignored; the op is never restarted.
- Reset mid-operation: immediate return to IDLE with all outputs 0.

Optional Feature:
- Macro: HAZ_PERF_EN.
- Defined:
  - Adds outputs perf_stall_cycles[31:0] (counts cycles with stall!=0) and perf_flush_events[31:0] (counts cycles with flush!=0).
  - Both counters saturate at 32'hFFFFFFFF and reset to 0.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then all inputs 0 -> stall=00000, flush=00000, md_busy=0, md_done=0.
- id_load_use=1 for 1 cycle -> stall=00011 that cycle only; with ex_branch_taken=1 in the same cycle -> flush=00011, stall=00000.
- MD_CYCLES=4, ex_md_start held high -> stall=00111 for exactly 4 cycles, md_busy=1 in cycles 2-4, then 1 cycle with md_done=1 and stall=00000, then IDLE with no restart.
- mem_wait=1 for 2 cycles during MD_BUSY -> stall=01111 for those cycles; total mult/div stall extends to 6 cycles; md_done is delayed by 2.
- exc_req=1 in the 2nd MD_BUSY cycle together with mem_wait=1 -> flush=11111, stall=00000; next cycle IDLE, md_done never asserted.
- With HAZ_PERF_EN: 3 load-use cycles plus 1 branch -> perf_stall_cycles=3, perf_flush_events=1; reset -> both 0.
